// File: rtl/rom_stream_pkg.sv
// Shared types and defaults for the 23256-style ROM stream reader.
package rom_stream_pkg;

  localparam int ROM_ADDR_W = 15;
  localparam int ROM_DATA_W = 8;
  localparam int ROM_LEN_W  = 16;
  localparam int ROM_DEPTH  = 32768;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    OUT,
    DONE
  } state_t;

endpackage

// File: rtl/rom_stream_reader.sv
// Sole master of the ROM port: fetches a burst byte by byte and streams it out on valid/ready.
// One byte per READ_LATENCY+2 cycles; out_data is held while out_ready is low and no new ROM read starts.
module rom_stream_reader
  import rom_stream_pkg::*;
#(
  parameter int ADDR_W       = ROM_ADDR_W,
  parameter int DATA_W       = ROM_DATA_W,
  parameter int LEN_W        = ROM_LEN_W,
  parameter int READ_LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [LEN_W-1:0]  length,
  input  logic              abort,
  output logic [ADDR_W-1:0] rom_addr,
  output logic              rom_oe,
  input  logic [DATA_W-1:0] rom_data,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              done
);

  localparam int WAIT_W = 3;

  state_t              r_state;
  state_t              w_next;
  logic [ADDR_W-1:0]   r_addr;
  logic                r_oe;
  logic [DATA_W-1:0]   r_data;
  logic                r_valid;
  logic                r_done;
  logic [LEN_W-1:0]    r_remaining;
  logic [WAIT_W-1:0]   r_wait;
  logic                w_fetch_last;
  logic                w_handshake;
  logic                w_last_byte;

  assign w_fetch_last = (r_wait == WAIT_W'(READ_LATENCY));
  assign w_handshake  = r_valid && out_ready;
  assign w_last_byte  = (r_remaining == LEN_W'(1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_next = (length == '0) ? DONE : FETCH;
        end
      end
      FETCH: begin
        if (abort) begin
          w_next = IDLE;
        end else if (w_fetch_last) begin
          w_next = OUT;
        end
      end
      OUT: begin
        // abort beats a same-cycle handshake: that byte is treated as never sent
        if (abort) begin
          w_next = IDLE;
        end else if (w_handshake) begin
          w_next = w_last_byte ? DONE : FETCH;
        end
      end
      DONE: begin
        w_next = IDLE;
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_addr      <= '0;
      r_oe        <= 1'b0;
      r_data      <= '0;
      r_valid     <= 1'b0;
      r_done      <= 1'b0;
      r_remaining <= '0;
      r_wait      <= '0;
    end else begin
      // done trails the DONE state by one edge so it drops together with busy
      r_done <= (r_state == DONE);
      case (r_state)
        IDLE: begin
          if (start && (length != '0)) begin
            r_addr      <= start_addr;
            r_remaining <= length;
            r_wait      <= '0;
            r_oe        <= 1'b1;
          end
        end
        FETCH: begin
          if (abort) begin
            r_oe   <= 1'b0;
            r_wait <= '0;
          end else if (w_fetch_last) begin
            r_data  <= rom_data;
            r_valid <= 1'b1;
            r_oe    <= 1'b0;
            r_wait  <= '0;
          end else begin
            r_wait <= r_wait + WAIT_W'(1);
          end
        end
        OUT: begin
          if (abort) begin
            r_valid <= 1'b0;
          end else if (w_handshake) begin
            r_valid     <= 1'b0;
            r_remaining <= r_remaining - LEN_W'(1);
            if (!w_last_byte) begin
              r_addr <= r_addr + ADDR_W'(1);
              r_oe   <= 1'b1;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign rom_addr  = r_addr;
  assign rom_oe    = r_oe;
  assign out_data  = r_data;
  assign out_valid = r_valid;
  assign busy      = (r_state != IDLE);
  assign done      = r_done;

endmodule

// File: tb/tb_rom_stream_reader.sv
// Scoreboard bench: DUT A (READ_LATENCY=1) and DUT B (READ_LATENCY=3), each on a matching ROM model.
module tb_rom_stream_reader;
  import rom_stream_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        a_start, b_start, a_abort, b_abort, a_ready, b_ready;
  logic [14:0] a_saddr, b_saddr, a_addr, b_addr;
  logic [15:0] a_len, b_len;
  logic        a_oe, b_oe, a_valid, b_valid, a_busy, b_busy, a_done, b_done;
  logic [7:0]  a_rom, b_rom, a_data, b_data;
  logic [7:0]  b_pipe [3];

  int checks = 0;
  int failures = 0;
  int a_done_cnt = 0, b_done_cnt = 0, a_stab_err = 0, a_oe_err = 0;
  logic [7:0]  a_exp[$], b_exp[$];
  logic [14:0] a_aexp[$];

  rom_stream_reader #(.READ_LATENCY(1)) u_a (
    .clk(clk), .rst_n(rst_n), .start(a_start), .start_addr(a_saddr), .length(a_len),
    .abort(a_abort), .rom_addr(a_addr), .rom_oe(a_oe), .rom_data(a_rom), .out_data(a_data),
    .out_valid(a_valid), .out_ready(a_ready), .busy(a_busy), .done(a_done)
  );

  rom_stream_reader #(.READ_LATENCY(3)) u_b (
    .clk(clk), .rst_n(rst_n), .start(b_start), .start_addr(b_saddr), .length(b_len),
    .abort(b_abort), .rom_addr(b_addr), .rom_oe(b_oe), .rom_data(b_rom), .out_data(b_data),
    .out_valid(b_valid), .out_ready(b_ready), .busy(b_busy), .done(b_done)
  );

  function automatic logic [7:0] rom_fn(input logic [14:0] a);
    return a[7:0] ^ {1'b0, a[14:8]};
  endfunction

  // ROM models: data appears READ_LATENCY edges after addr+oe
  always @(posedge clk) a_rom <= a_oe ? rom_fn(a_addr) : 8'hFF;
  always @(posedge clk) begin
    b_pipe[0] <= b_oe ? rom_fn(b_addr) : 8'hFF;
    b_pipe[1] <= b_pipe[0];
    b_pipe[2] <= b_pipe[1];
  end
  assign b_rom = b_pipe[2];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Monitor A: byte scoreboard, fetch-address scoreboard, hold stability, done count
  initial begin
    logic prev_oe, prev_hold;
    logic [7:0] prev_data;
    prev_oe = 1'b0; prev_hold = 1'b0; prev_data = '0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (a_valid && a_ready && !a_abort) begin
          if (a_exp.size() == 0) begin
            checks++; failures++;
            $display("FAIL a_extra_byte: got 0x%0h, expected no byte", a_data);
          end else chk("a_byte", a_data, a_exp.pop_front());
        end
        if (a_oe && !prev_oe) begin
          if (a_aexp.size() == 0) begin
            checks++; failures++;
            $display("FAIL a_extra_fetch: got addr 0x%0h, expected no fetch", a_addr);
          end else chk("a_fetch_addr", a_addr, a_aexp.pop_front());
        end
        if (a_done) a_done_cnt++;
        if (a_oe && a_valid) a_oe_err++;
        if (prev_hold && !(a_valid && a_data == prev_data)) a_stab_err++;
      end
      prev_oe   = a_oe;
      prev_hold = rst_n && a_valid && !a_ready && !a_abort;
      prev_data = a_data;
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (b_valid && b_ready) begin
          if (b_exp.size() == 0) begin
            checks++; failures++;
            $display("FAIL b_extra_byte: got 0x%0h, expected no byte", b_data);
          end else chk("b_byte", b_data, b_exp.pop_front());
        end
        if (b_done) b_done_cnt++;
      end
    end
  end

  function automatic logic vld(input bit s);
    return s ? b_valid : a_valid;
  endfunction

  function automatic logic dn(input bit s);
    return s ? b_done : a_done;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input bit s, input logic [14:0] addr, input logic [15:0] len);
    if (s) begin b_saddr = addr; b_len = len; b_start = 1'b1; end
    else begin a_saddr = addr; a_len = len; a_start = 1'b1; end
    step();
    a_start = 1'b0;
    b_start = 1'b0;
  endtask

  // Edges counted include the edge that accepted start
  task automatic wait_valid(input bit s, input string nm, input int exp);
    int n = 1;
    while (!vld(s) && n < 60) begin step(); n++; end
    chk(nm, n, exp);
  endtask

  task automatic gap(input bit s, input string nm, input int exp);
    int n;
    step();
    n = 1;
    while (vld(s) && n < 60) begin step(); n++; end
    while (!vld(s) && n < 60) begin step(); n++; end
    chk(nm, n, exp);
  endtask

  task automatic wait_done(input bit s, input string nm);
    int n = 0;
    while (!dn(s) && n < 80) begin step(); n++; end
    chk({nm, "_seen"}, dn(s), 1);
    chk({nm, "_busy_low"}, s ? b_busy : a_busy, 0);
    step();
    step();
  endtask

  initial begin
    int d0;
    int n;
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int d0, n;
    rst_n = 1'b0;
    a_start = 0; b_start = 0; a_abort = 0; b_abort = 0; a_ready = 1; b_ready = 1;
    a_saddr = '0; b_saddr = '0; a_len = '0; b_len = '0;
    repeat (3) step();
    chk("reset_a", {a_addr, a_oe, a_data, a_valid, a_busy, a_done}, 0);
    chk("reset_b", {b_addr, b_oe, b_data, b_valid, b_busy, b_done}, 0);
    rst_n = 1'b1;
    step();

    // Basic 3-byte burst from 0
    a_exp = '{8'h00, 8'h01, 8'h02};
    a_aexp = '{15'h0000, 15'h0001, 15'h0002};
    d0 = a_done_cnt;
    issue(0, 15'h0000, 16'd3);
    chk("basic_busy", a_busy, 1);
    wait_valid(0, "basic_latency", 3);
    gap(0, "basic_gap1", 3);
    gap(0, "basic_gap2", 3);
    wait_done(0, "basic_done");
    chk("basic_done_once", a_done_cnt - d0, 1);
    chk("basic_drained", a_exp.size() + a_aexp.size(), 0);

    // Backpressure: hold 5 cycles per byte
    a_ready = 1'b0;
    a_exp = '{8'h10, 8'h11};
    a_aexp = '{15'h0010, 15'h0011};
    issue(0, 15'h0010, 16'd2);
    for (int k = 0; k < 2; k++) begin
      n = 0;
      while (!a_valid && n < 60) begin step(); n++; end
      repeat (5) step();
      chk("bp_held_data", a_data, (k == 0) ? 8'h10 : 8'h11);
      a_ready = 1'b1;
      step();
      a_ready = 1'b0;
    end
    a_ready = 1'b1;
    wait_done(0, "bp_done");
    chk("bp_drained", a_exp.size() + a_aexp.size(), 0);

    // Address wrap at the top of the ROM
    a_exp = '{8'h81, 8'h80, 8'h00, 8'h01};
    a_aexp = '{15'h7FFE, 15'h7FFF, 15'h0000, 15'h0001};
    issue(0, 15'h7FFE, 16'd4);
    wait_done(0, "wrap_done");
    chk("wrap_drained", a_exp.size() + a_aexp.size(), 0);

    // Empty burst: done two edges after start, no byte
    d0 = a_done_cnt;
    issue(0, 15'h0000, 16'd0);
    n = 1;
    while (!a_done && n < 60) begin step(); n++; end
    chk("empty_done_latency", n, 2);
    step();
    step();
    chk("empty_done_once", a_done_cnt - d0, 1);

    // Start while busy is ignored
    d0 = a_done_cnt;
    a_exp = '{8'h20, 8'h21};
    a_aexp = '{15'h0020, 15'h0021};
    issue(0, 15'h0020, 16'd2);
    issue(0, 15'h1234, 16'd7);
    wait_done(0, "ign_done");
    repeat (4) step();
    chk("ign_done_once", a_done_cnt - d0, 1);
    chk("ign_drained", a_exp.size() + a_aexp.size(), 0);

    // Abort during the second fetch of a 5-byte burst
    a_exp = '{8'h40};
    a_aexp = '{15'h0040, 15'h0041};
    issue(0, 15'h0040, 16'd5);
    wait_valid(0, "abort_latency", 3);
    step();
    chk("abort_in_fetch", a_oe, 1);
    d0 = a_done_cnt;
    a_abort = 1'b1;
    step();
    a_abort = 1'b0;
    chk("abort_idle", {a_busy, a_oe, a_valid}, 0);
    repeat (5) step();
    chk("abort_no_done", a_done_cnt - d0, 0);
    chk("abort_drained", a_exp.size() + a_aexp.size(), 0);

    // Reset in OUT, then a fresh burst
    a_ready = 1'b0;
    a_aexp = '{15'h0050};
    issue(0, 15'h0050, 16'd3);
    n = 0;
    while (!a_valid && n < 60) begin step(); n++; end
    chk("rst_reached_out", a_valid, 1);
    rst_n = 1'b0;
    step();
    chk("rst_mid_outputs", {a_addr, a_oe, a_data, a_valid, a_busy, a_done}, 0);
    rst_n = 1'b1;
    a_ready = 1'b1;
    d0 = a_done_cnt;
    a_exp = '{8'h60};
    a_aexp = '{15'h0060};
    issue(0, 15'h0060, 16'd1);
    wait_valid(0, "rst_fresh_latency", 3);
    wait_done(0, "rst_fresh_done");
    chk("rst_fresh_done_once", a_done_cnt - d0, 1);
    chk("rst_drained", a_exp.size() + a_aexp.size(), 0);

    // READ_LATENCY=3 instance
    b_exp = '{8'h01, 8'h00};
    d0 = b_done_cnt;
    issue(1, 15'h0100, 16'd2);
    wait_valid(1, "rl3_latency", 5);
    gap(1, "rl3_gap", 5);
    wait_done(1, "rl3_done");
    chk("rl3_done_once", b_done_cnt - d0, 1);
    chk("rl3_drained", b_exp.size(), 0);

    chk("a_hold_stable", a_stab_err, 0);
    chk("a_no_read_in_out", a_oe_err, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
